mcc_ctrl_core: RTL and testbench
================================

# mcc_ctrl_core

Sequencing core of the 24-bit multi-cycle CPU. It holds the 11-bit program counter, the ALU with its A/B source muxes, the ALU-output holding register and the multi-cycle control FSM. Instruction RAM, instruction register, register file, decoder and data RAM stay outside this block. They supply the decoded opcode, operands and immediate, and consume the PC, ALU result and control strobes.

## Interface
- DATA_W, 24: datapath and ALU width.
- ADDR_W, 11: PC and memory address width.
- OPC_W, 6: opcode width.
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- opcode  in  OPC_W  decoded opcode of the instruction register contents.
- src1_data  in  DATA_W  register-file read port 1.
- src2_data  in  DATA_W  register-file read port 2.
- immediate  in  DATA_W  immediate, already extended by the decoder.
- pc  out  ADDR_W  current program counter (instruction RAM address).
- alu_result  out  DATA_W  combinational ALU output.
- alu_out_reg  out  DATA_W  ALU output registered every cycle; also the data RAM address.
- zero  out  1  alu_result == 0.
- ir_write, mem_to_reg, mem_read_not_write, mem_select, reg_write  out  1 each  control strobes.
- state  out  3  FSM state, for debug and verification.

## Operation
ALU, 4-bit op:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL A by B[4:0]; 6 SRL A by B[4:0], logical.
- 7 SLT: signed compare, result 1 or 0.
- 8 PASS B.
- Ops 9-15 yield 0.
- All arithmetic is modulo 2^24; there is no carry or overflow output.

ALU sources:
- A: 0 = zero-extended pc; 1 = src1_data.
- B: 0 = src2_data; 1 = constant 1; 2 = immediate; 3 = constant 1023.

PC mux:
- 0 = alu_result[10:0], used for PC+1.
- 1 = alu_out_reg[10:0], used for the branch target.
- 2 = immediate[10:0], used for jumps.
- 3 = reset address 0 (2048 mod 2^11).

Opcodes:
- 0x00 NOP; 0x01-0x05 ADD SUB AND OR XOR; 0x06 SLL; 0x07 SRL; 0x08 SLT.
- 0x09 ADDI, 0x0A LW, 0x0B SW, 0x0C BEQ, 0x0D BNE, 0x0E JMP, 0x0F LI (rd = imm), 0x3F HALT.
- Any other opcode behaves as NOP.

Default strobes in every state unless listed: all 0, except mem_read_not_write = 1.

FSM:
- FETCH(0): ir_write=1; A=pc, B=1, ADD; PC mux 0; PC written. Next DECODE.
- DECODE(1): A=pc, B=imm, ADD, giving the branch target latched into alu_out_reg. NOP goes to FETCH, HALT goes to HALT, all others go to EXECUTE.
- EXECUTE(2), by opcode:
  - R-type: A=src1, B=src2, op from opcode.
  - ADDI: A=src1, B=imm, ADD.
  - LI: B=imm, PASS.
  - R-type, ADDI and LI then go to WRITEBACK.
  - LW/SW: A=src1, B=imm, ADD, then MEMORY.
  - BEQ/BNE: A=src1, B=src2, SUB. PC is written from mux 1 when zero=1 (BEQ) or zero=0 (BNE). Then FETCH.
  - JMP: PC written from mux 2, then FETCH.
- MEMORY(3): mem_select=1.
  - LW: mem_read_not_write=1, then WRITEBACK.
  - SW: mem_read_not_write=0, then FETCH.
- WRITEBACK(4): reg_write=1; mem_to_reg=1 for LW, else 0. Next FETCH.
- HALT(5): all enables 0. Exits only via reset.
- Encodings 6-7 go to FETCH.

## Timing
- Reset, asynchronous: state=FETCH, pc=0, alu_out_reg=0.
- Outputs while reset is held or immediately after it: ir_write=1, mem_read_not_write=1, all other strobes 0, zero reflects alu_result = 0+1 = 1, so zero=0.
- Strobes are combinational from state and opcode. The branch PC write also depends on zero within EXECUTE.
- alu_out_reg loads alu_result on every rising edge; there is no enable.
- PC loads only on edges where the PC write is asserted.
- Cycles per instruction:
  - NOP 2.
  - BEQ/BNE/JMP 3.
  - R-type/ADDI/LI/SW 4.
  - LW 5.
- Reset asserted mid-instruction aborts it with no further strobes. Fetch restarts at address 0 on the first edge after release.
- PC wraps 2047 -> 0.

## Test plan
- Reset, then opcode 0x00 held: pc steps 1, 2, 3 every 2 cycles; state alternates 0/1.
- ADD with src1=5, src2=7: EXECUTE alu_result=12. WRITEBACK has reg_write=1, mem_to_reg=0. 4 cycles total.
- LW with src1=0x10, imm=4: alu_out_reg=0x14 in MEMORY with mem_select=1 and mem_read_not_write=1. WRITEBACK has mem_to_reg=1.
- SW: MEMORY has mem_select=1, mem_read_not_write=0. Next state FETCH, reg_write never 1.
- BEQ at pc=10 with imm=5: src1=src2 gives pc=16; src1≠src2 gives pc=11. BNE gives the opposite. JMP with imm=0x7FF gives pc=2047, and the next FETCH wraps it to 0.
- HALT holds state 5 indefinitely; asserting reset in EXECUTE returns state 0 and pc 0 immediately, asynchronously.

Source files
------------

// File: rtl/mcc_ctrl_core.sv
// Sequencing core of the 24-bit multi-cycle CPU.
// This block holds the program counter, the ALU and its source muxes, the ALU-output
// register and the multi-cycle control FSM. Strobes are decoded combinationally from
// the current state and the opcode.
module mcc_ctrl_core #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned OPC_W  = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [DATA_W-1:0] i_src1_data,
  input  logic [DATA_W-1:0] i_src2_data,
  input  logic [DATA_W-1:0] i_immediate,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_alu_out_reg,
  output logic              o_zero,
  output logic              o_ir_write,
  output logic              o_mem_to_reg,
  output logic              o_mem_read_not_write,
  output logic              o_mem_select,
  output logic              o_reg_write,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OpAdd  = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OpSlt  = OPC_W'(8'h08);
  localparam logic [OPC_W-1:0] OpAddi = OPC_W'(8'h09);
  localparam logic [OPC_W-1:0] OpLw   = OPC_W'(8'h0A);
  localparam logic [OPC_W-1:0] OpSw   = OPC_W'(8'h0B);
  localparam logic [OPC_W-1:0] OpBeq  = OPC_W'(8'h0C);
  localparam logic [OPC_W-1:0] OpBne  = OPC_W'(8'h0D);
  localparam logic [OPC_W-1:0] OpJmp  = OPC_W'(8'h0E);
  localparam logic [OPC_W-1:0] OpLi   = OPC_W'(8'h0F);
  localparam logic [OPC_W-1:0] OpHalt = OPC_W'(8'h3F);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSlt  = 4'd7;
  localparam logic [3:0] AluPass = 4'd8;

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu_result;
  logic [3:0]        w_alu_op;
  logic              w_a_sel;
  logic [1:0]        w_b_sel;
  logic [1:0]        w_pc_sel;
  logic              w_pc_write_uncond;
  logic              w_br_eq;
  logic              w_br_ne;
  logic              w_pc_write;
  logic              w_zero;
  logic              w_is_rtype;
  logic              w_is_known;

  assign w_is_rtype = (i_opcode >= OpAdd) && (i_opcode <= OpSlt);
  assign w_is_known = w_is_rtype || (i_opcode == OpAddi) || (i_opcode == OpLw) ||
                      (i_opcode == OpSw) || (i_opcode == OpBeq) || (i_opcode == OpBne) ||
                      (i_opcode == OpJmp) || (i_opcode == OpLi);

  // Control decode: ALU steering, PC write requests, strobes and next state.
  always_comb begin
    w_a_sel              = 1'b0;
    w_b_sel              = 2'd0;
    w_alu_op             = AluAdd;
    w_pc_sel             = 2'd0;
    w_pc_write_uncond    = 1'b0;
    w_br_eq              = 1'b0;
    w_br_ne              = 1'b0;
    o_ir_write           = 1'b0;
    o_mem_to_reg         = 1'b0;
    o_mem_read_not_write = 1'b1;
    o_mem_select         = 1'b0;
    o_reg_write          = 1'b0;
    w_next_state         = StFetch;
    case (r_state)
      StFetch: begin
        o_ir_write        = 1'b1;
        w_b_sel           = 2'd1;
        w_pc_write_uncond = 1'b1;
        w_next_state      = StDecode;
      end
      StDecode: begin
        // Branch target = (pc already advanced) + imm, parked in alu_out_reg.
        w_b_sel = 2'd2;
        if (i_opcode == OpHalt)  w_next_state = StHalt;
        else if (w_is_known)     w_next_state = StExecute;
        else                     w_next_state = StFetch;
      end
      StExecute: begin
        w_a_sel = 1'b1;
        if (w_is_rtype) begin
          w_alu_op     = 4'(i_opcode - OpAdd);
          w_next_state = StWriteback;
        end else if (i_opcode == OpAddi) begin
          w_b_sel      = 2'd2;
          w_next_state = StWriteback;
        end else if (i_opcode == OpLi) begin
          w_b_sel      = 2'd2;
          w_alu_op     = AluPass;
          w_next_state = StWriteback;
        end else if ((i_opcode == OpLw) || (i_opcode == OpSw)) begin
          w_b_sel      = 2'd2;
          w_next_state = StMemory;
        end else if ((i_opcode == OpBeq) || (i_opcode == OpBne)) begin
          w_alu_op = AluSub;
          w_pc_sel = 2'd1;
          w_br_eq  = (i_opcode == OpBeq);
          w_br_ne  = (i_opcode == OpBne);
        end else if (i_opcode == OpJmp) begin
          w_pc_sel          = 2'd2;
          w_pc_write_uncond = 1'b1;
        end
      end
      StMemory: begin
        o_mem_select = 1'b1;
        if (i_opcode == OpLw) begin
          w_next_state = StWriteback;
        end else begin
          o_mem_read_not_write = 1'b0;
        end
      end
      StWriteback: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (i_opcode == OpLw);
      end
      StHalt: begin
        w_next_state = StHalt;
      end
      default: w_next_state = StFetch;
    endcase
  end

  // ALU operand muxes.
  always_comb begin
    w_a = w_a_sel ? i_src1_data : {{(DATA_W-ADDR_W){1'b0}}, r_pc};
    case (w_b_sel)
      2'd0:    w_b = i_src2_data;
      2'd1:    w_b = DATA_W'(1);
      2'd2:    w_b = i_immediate;
      default: w_b = DATA_W'(1023);
    endcase
  end

  // ALU; all arithmetic wraps at DATA_W bits.
  always_comb begin
    case (w_alu_op)
      AluAdd:  w_alu_result = w_a + w_b;
      AluSub:  w_alu_result = w_a - w_b;
      AluAnd:  w_alu_result = w_a & w_b;
      AluOr:   w_alu_result = w_a | w_b;
      AluXor:  w_alu_result = w_a ^ w_b;
      AluSll:  w_alu_result = w_a << w_b[4:0];
      AluSrl:  w_alu_result = w_a >> w_b[4:0];
      AluSlt:  w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      AluPass: w_alu_result = w_b;
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero = (w_alu_result == '0);
  // Branch qualification is kept outside the decode block to avoid a zero->control loop.
  assign w_pc_write = w_pc_write_uncond | (w_br_eq & w_zero) | (w_br_ne & ~w_zero);

  // PC source mux.
  always_comb begin
    case (w_pc_sel)
      2'd0:    w_pc_next = w_alu_result[ADDR_W-1:0];
      2'd1:    w_pc_next = r_alu_out[ADDR_W-1:0];
      2'd2:    w_pc_next = i_immediate[ADDR_W-1:0];
      default: w_pc_next = '0;
    endcase
  end

  // State, PC and ALU-output register updates.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StFetch;
      r_pc      <= '0;
      r_alu_out <= '0;
    end else begin
      r_state   <= w_next_state;
      r_alu_out <= w_alu_result;
      if (w_pc_write) r_pc <= w_pc_next;
    end
  end

  assign o_pc          = r_pc;
  assign o_alu_result  = w_alu_result;
  assign o_alu_out_reg = r_alu_out;
  assign o_zero        = w_zero;
  assign o_state       = r_state;

endmodule

// File: tb/tb_mcc_ctrl_core.sv
// Self-checking bench for mcc_ctrl_core: an instruction-level model expands each
// instruction into its expected per-cycle outputs; a negedge process compares them.
module tb_mcc_ctrl_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [23:0] src1, src2, imm;
  logic [10:0] pc;
  logic [23:0] alu_result, alu_out_reg;
  logic        zero, ir_write, mem_to_reg, mrnw, msel, reg_write;
  logic [2:0]  state;

  mcc_ctrl_core #(.DATA_W(24), .ADDR_W(11), .OPC_W(6)) dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_opcode             (opcode),
    .i_src1_data          (src1),
    .i_src2_data          (src2),
    .i_immediate          (imm),
    .o_pc                 (pc),
    .o_alu_result         (alu_result),
    .o_alu_out_reg        (alu_out_reg),
    .o_zero               (zero),
    .o_ir_write           (ir_write),
    .o_mem_to_reg         (mem_to_reg),
    .o_mem_read_not_write (mrnw),
    .o_mem_select         (msel),
    .o_reg_write          (reg_write),
    .o_state              (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    bit          irw, m2r, mrnw, msel, rw, chk_mrnw;
    logic [10:0] pc;
    bit          chk_res;
    logic [23:0] res;
    bit          chk_aor;
    logic [23:0] aor;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] m_pc = '0;
  bit          prev_known = 1'b1;
  logic [23:0] prev_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the operation table.
  function automatic logic [23:0] alu(input int op, input logic [23:0] a, input logic [23:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[4:0];
      6: return a >> b[4:0];
      7: return ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
      8: return b;
      default: return 24'd0;
    endcase
  endfunction

  // Queue the expected outputs of one cycle; alu_out_reg must hold the previous result.
  task automatic push(input logic [2:0] st, input bit irw, input bit m2r, input bit rd,
                      input bit sel, input bit rw, input bit chk_rd, input bit chk_res,
                      input logic [23:0] res);
    exp_t e;
    e.st = st; e.irw = irw; e.m2r = m2r; e.mrnw = rd; e.msel = sel; e.rw = rw;
    e.chk_mrnw = chk_rd; e.pc = m_pc; e.chk_res = chk_res; e.res = res;
    e.chk_aor = prev_known; e.aor = prev_res;
    q.push_back(e);
    prev_known = chk_res;
    prev_res   = res;
  endtask

  // Instruction-level model: expands one instruction into its cycles, updates model PC.
  task automatic model_instr(input logic [5:0] op, input logic [23:0] s1, input logic [23:0] s2,
                             input logic [23:0] im, output int n);
    logic [23:0] tgt, r;
    push(3'd0, 1, 0, 1, 0, 0, 1, 1, {13'd0, m_pc} + 24'd1);
    m_pc = m_pc + 11'd1;
    tgt = {13'd0, m_pc} + im;
    push(3'd1, 0, 0, 1, 0, 0, 1, 1, tgt);
    n = 2;
    if (op >= 6'h01 && op <= 6'h0F) begin
      if (op <= 6'h08 || op == 6'h09 || op == 6'h0F) begin
        r = (op == 6'h09) ? s1 + im : (op == 6'h0F) ? im : alu(int'(op) - 1, s1, s2);
        push(3'd2, 0, 0, 1, 0, 0, 1, 1, r);
        push(3'd4, 0, 0, 1, 0, 1, 1, 0, 24'd0);
        n += 2;
      end else if (op == 6'h0A) begin
        push(3'd2, 0, 0, 1, 0, 0, 1, 1, s1 + im);
        push(3'd3, 0, 0, 1, 1, 0, 1, 0, 24'd0);
        push(3'd4, 0, 1, 1, 0, 1, 1, 0, 24'd0);
        n += 3;
      end else if (op == 6'h0B) begin
        push(3'd2, 0, 0, 1, 0, 0, 1, 1, s1 + im);
        push(3'd3, 0, 0, 0, 1, 0, 1, 0, 24'd0);
        n += 2;
      end else if (op == 6'h0C || op == 6'h0D) begin
        r = s1 - s2;
        push(3'd2, 0, 0, 1, 0, 0, 1, 1, r);
        if ((r == 24'd0) == (op == 6'h0C)) m_pc = tgt[10:0];
        n += 1;
      end else begin
        push(3'd2, 0, 0, 1, 0, 0, 1, 0, 24'd0);
        m_pc = im[10:0];
        n += 1;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [23:0] s1, input logic [23:0] s2,
                        input logic [23:0] im);
    opcode = op; src1 = s1; src2 = s2; imm = im;
  endtask

  task automatic run(input logic [5:0] op, input logic [23:0] s1, input logic [23:0] s2,
                     input logic [23:0] im);
    int n;
    set_in(op, s1, s2, im);
    model_instr(op, s1, s2, im, n);
    step(n);
  endtask

  // Single compare process against the model queue.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("state", {29'd0, state}, {29'd0, e.st});
      check("pc", {21'd0, pc}, {21'd0, e.pc});
      check("ir_write", {31'd0, ir_write}, {31'd0, e.irw});
      check("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, e.m2r});
      check("mem_select", {31'd0, msel}, {31'd0, e.msel});
      check("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
      if (e.chk_mrnw) check("mem_read_not_write", {31'd0, mrnw}, {31'd0, e.mrnw});
      if (e.chk_res) begin
        check("alu_result", {8'd0, alu_result}, {8'd0, e.res});
        check("zero", {31'd0, zero}, {31'd0, (e.res == 24'd0)});
      end
      if (e.chk_aor) check("alu_out_reg", {8'd0, alu_out_reg}, {8'd0, e.aor});
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    set_in(6'h00, 24'd0, 24'd0, 24'd0);
    #2;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", {21'd0, pc}, 32'd0);
    check("rst_aor", {8'd0, alu_out_reg}, 32'd0);
    check("rst_alu_result", {8'd0, alu_result}, 32'd1);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ir_write", {31'd0, ir_write}, 32'd1);
    check("rst_mrnw", {31'd0, mrnw}, 32'd1);
    check("rst_strobes", {29'd0, mem_to_reg, msel, reg_write}, 32'd0);
    step(1);
    check("rst_held_pc", {21'd0, pc}, 32'd0);
    rst = 1'b0;

    // NOPs: pc steps 1, 2, 3
    run(6'h00, 24'd0, 24'd0, 24'd0);
    check("nop_pc1", {21'd0, pc}, 32'd1);
    run(6'h00, 24'd0, 24'd0, 24'd0);
    check("nop_pc2", {21'd0, pc}, 32'd2);
    run(6'h00, 24'd0, 24'd0, 24'd0);
    check("nop_pc3", {21'd0, pc}, 32'd3);

    // ADD 5+7 with hand-checked literals
    set_in(6'h01, 24'd5, 24'd7, 24'd0);
    model_instr(6'h01, 24'd5, 24'd7, 24'd0, n);
    check("add_cycles", n, 32'd4);
    step(2);
    check("add_exec_state", {29'd0, state}, 32'd2);
    check("add_exec_result", {8'd0, alu_result}, 32'd12);
    step(1);
    check("add_wb_reg_write", {31'd0, reg_write}, 32'd1);
    check("add_wb_mem_to_reg", {31'd0, mem_to_reg}, 32'd0);
    check("add_wb_aor", {8'd0, alu_out_reg}, 32'd12);
    step(1);
    check("add_next_fetch", {29'd0, state}, 32'd0);

    // Remaining ALU ops through the model
    run(6'h02, 24'd5, 24'd7, 24'd0);              // SUB -> 0xFFFFFE
    run(6'h03, 24'hF0F0F0, 24'h0FF00F, 24'd0);    // AND
    run(6'h04, 24'hF00000, 24'h00000F, 24'd0);    // OR
    run(6'h05, 24'hAAAAAA, 24'hFFFFFF, 24'd0);    // XOR
    run(6'h06, 24'd1, 24'h000023, 24'd0);         // SLL by 3 -> 8
    run(6'h07, 24'h800000, 24'd4, 24'd0);         // SRL -> 0x080000
    run(6'h08, 24'hFFFFFF, 24'd1, 24'd0);         // SLT -1 < 1 -> 1
    run(6'h08, 24'd1, 24'hFFFFFF, 24'd0);         // SLT 1 < -1 -> 0
    run(6'h09, 24'd100, 24'd0, 24'hFFFFFF);       // ADDI -> 99
    run(6'h0F, 24'd3, 24'd4, 24'h123456);         // LI
    run(6'h20, 24'd0, 24'd0, 24'd0);              // unknown acts as NOP

    // LW
    set_in(6'h0A, 24'h10, 24'd0, 24'd4);
    model_instr(6'h0A, 24'h10, 24'd0, 24'd4, n);
    step(3);
    check("lw_mem_aor", {8'd0, alu_out_reg}, 32'h14);
    check("lw_mem_select", {31'd0, msel}, 32'd1);
    check("lw_mem_rnw", {31'd0, mrnw}, 32'd1);
    step(1);
    check("lw_wb_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
    step(n - 4);

    // SW
    run(6'h0B, 24'h20, 24'd0, 24'd8);
    check("sw_next_fetch", {29'd0, state}, 32'd0);

    // Branches from pc=10 with imm=5
    run(6'h0E, 24'd0, 24'd0, 24'd10);
    check("jmp_pc10", {21'd0, pc}, 32'd10);
    run(6'h0C, 24'd3, 24'd3, 24'd5);
    check("beq_taken_pc", {21'd0, pc}, 32'd16);
    run(6'h0E, 24'd0, 24'd0, 24'd10);
    run(6'h0C, 24'd3, 24'd4, 24'd5);
    check("beq_not_taken_pc", {21'd0, pc}, 32'd11);
    run(6'h0E, 24'd0, 24'd0, 24'd10);
    run(6'h0D, 24'd3, 24'd3, 24'd5);
    check("bne_not_taken_pc", {21'd0, pc}, 32'd11);
    run(6'h0E, 24'd0, 24'd0, 24'd10);
    run(6'h0D, 24'd3, 24'd4, 24'd5);
    check("bne_taken_pc", {21'd0, pc}, 32'd16);

    // JMP to 2047 then wrap on fetch
    run(6'h0E, 24'd0, 24'd0, 24'h0007FF);
    check("jmp_pc2047", {21'd0, pc}, 32'd2047);
    run(6'h00, 24'd0, 24'd0, 24'd0);
    check("pc_wrap", {21'd0, pc}, 32'd0);

    // Asynchronous reset in EXECUTE
    run(6'h00, 24'd0, 24'd0, 24'd0);
    set_in(6'h01, 24'd1, 24'd2, 24'd0);
    step(2);
    check("pre_reset_state", {29'd0, state}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", {29'd0, state}, 32'd0);
    check("async_rst_pc", {21'd0, pc}, 32'd0);
    check("async_rst_aor", {8'd0, alu_out_reg}, 32'd0);
    check("async_rst_reg_write", {31'd0, reg_write}, 32'd0);
    set_in(6'h00, 24'd0, 24'd0, 24'd0);
    step(1);
    rst = 1'b0;
    m_pc = '0;
    prev_known = 1'b1;
    prev_res = '0;
    run(6'h00, 24'd0, 24'd0, 24'd0);
    check("post_rst_pc", {21'd0, pc}, 32'd1);

    // HALT holds state 5
    set_in(6'h3F, 24'd0, 24'd0, 24'd0);
    model_instr(6'h3F, 24'd0, 24'd0, 24'd0, n);
    for (int i = 0; i < 6; i++) push(3'd5, 0, 0, 1, 0, 0, 0, 0, 24'd0);
    step(n + 6);
    check("halt_state", {29'd0, state}, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("halt_rst_state", {29'd0, state}, 32'd0);
    check("halt_rst_pc", {21'd0, pc}, 32'd0);
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
